// File: rtl/morse_pkg.sv
// Shared types and constants for the SOS detector: symbol kinds, sequencer states
// and the target dot/dash pattern.
package morse_pkg;

  typedef enum logic [1:0] {SYM_DOT, SYM_DASH, SYM_BAD} sym_e;
  typedef enum logic [1:0] {IDLE, MATCH, HIT} state_e;

  localparam int SOS_LEN = 9;
  // Bit p set means a dash is expected at symbol index p.
  localparam logic [SOS_LEN-1:0] SOS_PATTERN = 9'b000111000;

  function automatic logic expect_dash(input logic [3:0] p);
    return SOS_PATTERN[p];
  endfunction

endpackage

// File: rtl/sos_sequencer_if.sv
// Serial Morse input and symbol/match status outputs of the SOS sequencer.
interface sos_sequencer_if;

  logic       in;
  logic       sym_valid;
  logic       sym_dash;
  logic       busy;
  logic [3:0] progress;
  logic       sos;
  logic       err;

  modport master (output in, input sym_valid, sym_dash, busy, progress, sos, err);
  modport slave  (input in, output sym_valid, sym_dash, busy, progress, sos, err);

endinterface

// File: rtl/morse_sym_classifier.sv
// Turns runs of 1s into dot/dash/bad symbols one cycle after the terminating 0,
// and tracks the length of the current run of 0s.
module morse_sym_classifier #(
  parameter int DOT_LEN  = 1,
  parameter int DASH_LEN = 3,
  parameter int RUN_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_i,
  output logic             sym_valid_o,
  output logic             sym_dash_o,
  output logic             bad_pulse_o,
  output logic [RUN_W-1:0] gap_o
);
  import morse_pkg::*;

  localparam logic [RUN_W-1:0] SAT      = '1;
  localparam logic [RUN_W-1:0] DOT_CNT  = RUN_W'(DOT_LEN);
  localparam logic [RUN_W-1:0] DASH_CNT = RUN_W'(DASH_LEN);

  logic [RUN_W-1:0] run_q, run_d, gap_q, gap_d;
  logic             sym_valid_q, sym_valid_d;
  logic             sym_dash_q, sym_dash_d;
  logic             bad_q, bad_d;
  logic             term;
  sym_e             kind;

  always_comb begin
    kind = SYM_BAD;
    if (run_q == DOT_CNT)       kind = SYM_DOT;
    else if (run_q == DASH_CNT) kind = SYM_DASH;

    // Both counters saturate so a stuck line cannot wrap into a valid length.
    run_d = in_i ? ((run_q == SAT) ? run_q : run_q + 1'b1) : '0;
    gap_d = in_i ? '0 : ((gap_q == SAT) ? gap_q : gap_q + 1'b1);

    term        = !in_i && (run_q != '0);
    sym_valid_d = term && (kind != SYM_BAD);
    sym_dash_d  = term && (kind == SYM_DASH);
    bad_d       = term && (kind == SYM_BAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q       <= '0;
      gap_q       <= '0;
      sym_valid_q <= 1'b0;
      sym_dash_q  <= 1'b0;
      bad_q       <= 1'b0;
    end else begin
      run_q       <= run_d;
      gap_q       <= gap_d;
      sym_valid_q <= sym_valid_d;
      sym_dash_q  <= sym_dash_d;
      bad_q       <= bad_d;
    end
  end

  assign sym_valid_o = sym_valid_q;
  assign sym_dash_o  = sym_dash_q;
  assign bad_pulse_o = bad_q;
  assign gap_o       = gap_q;

endmodule

// File: rtl/sos_sequencer.sv
// Matches classified Morse symbols against dot-dot-dot dash-dash-dash dot-dot-dot;
// pulses sos on a full match and err when a partial match times out.
module sos_sequencer #(
  parameter int DOT_LEN  = 1,
  parameter int DASH_LEN = 3,
  parameter int TIMEOUT  = 8,
  parameter int RUN_W    = 4
) (
  input  logic           clk,
  input  logic           rst,
  sos_sequencer_if.slave bus
);
  import morse_pkg::*;

  localparam logic [RUN_W-1:0] TO_CNT = RUN_W'(TIMEOUT);
  localparam logic [3:0]       LAST   = 4'(SOS_LEN - 1);

  logic             sym_valid, sym_dash, bad_pulse;
  logic [RUN_W-1:0] gap;
  state_e           state_q;
  logic [3:0]       progress_q;
  logic [3:0]       base;
  logic             sos_q, err_q;

  morse_sym_classifier #(
    .DOT_LEN (DOT_LEN),
    .DASH_LEN(DASH_LEN),
    .RUN_W   (RUN_W)
  ) u_cls (
    .clk        (clk),
    .rst        (rst),
    .in_i       (bus.in),
    .sym_valid_o(sym_valid),
    .sym_dash_o (sym_dash),
    .bad_pulse_o(bad_pulse),
    .gap_o      (gap)
  );

  // HIT never carries over: a symbol seen there is judged as a fresh start.
  assign base = (state_q == HIT) ? 4'd0 : progress_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      progress_q <= 4'd0;
      sos_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sos_q <= 1'b0;
      err_q <= 1'b0;
      if (bad_pulse) begin
        state_q    <= IDLE;
        progress_q <= 4'd0;
      end else if (sym_valid) begin
        if (sym_dash == expect_dash(base)) begin
          if (base == LAST) begin
            state_q    <= HIT;
            progress_q <= 4'(SOS_LEN);
            sos_q      <= 1'b1;
          end else begin
            state_q    <= MATCH;
            progress_q <= base + 4'd1;
          end
        end else if (!sym_dash) begin
          // An unexpected dot can still be the first dot of a new SOS.
          state_q    <= MATCH;
          progress_q <= 4'd1;
        end else begin
          state_q    <= IDLE;
          progress_q <= 4'd0;
        end
      end else if (state_q == MATCH && gap == TO_CNT) begin
        err_q      <= 1'b1;
        state_q    <= IDLE;
        progress_q <= 4'd0;
      end else if (state_q == HIT) begin
        state_q    <= IDLE;
        progress_q <= 4'd0;
      end
    end
  end

  assign bus.sym_valid = sym_valid;
  assign bus.sym_dash  = sym_dash;
  assign bus.busy      = (state_q == MATCH);
  assign bus.progress  = progress_q;
  assign bus.sos       = sos_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_sos_sequencer.sv
// Directed bench for sos_sequencer: full match, bad run, timeout, mismatch restart,
// reset mid-match and run saturation.
module tb_sos_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n_sym = 0, n_sos = 0, n_err = 0;
  int   s0, e0, q0;
  logic [8:0] pat = 9'b000111000;

  sos_sequencer_if bus ();

  sos_sequencer dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.sym_valid) n_sym++;
      if (bus.sos)       n_sos++;
      if (bus.err)       n_err++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic bit_(input logic b);
    bus.in = b;
    @(posedge clk);
    #1;
  endtask

  // Symbol followed by its single terminating 0; sym_valid is visible on return.
  task automatic sym(input logic dash);
    repeat (dash ? 3 : 1) bit_(1'b1);
    bit_(1'b0);
    chk("sym_valid", {7'd0, bus.sym_valid}, 8'd1);
    chk("sym_dash", {7'd0, bus.sym_dash}, {7'd0, dash});
  endtask

  // Sends pattern symbols start..8; progress lags its symbol by one cycle.
  task automatic run_from(input int start);
    for (int i = start; i < 9; i++) begin
      sym(pat[i]);
      chk("progress_step", {4'd0, bus.progress}, 8'(i));
    end
    chk("busy_before_hit", {7'd0, bus.busy}, 8'd1);
    bit_(1'b0);
    chk("sos_hit", {7'd0, bus.sos}, 8'd1);
    chk("progress_hit", {4'd0, bus.progress}, 8'd9);
    chk("busy_hit", {7'd0, bus.busy}, 8'd0);
    bit_(1'b0);
    chk("sos_after", {7'd0, bus.sos}, 8'd0);
    chk("progress_after", {4'd0, bus.progress}, 8'd0);
  endtask

  initial begin
    bus.in = 1'b0;
    rst = 1'b1;
    bit_(1'b0);
    bit_(1'b0);
    chk("rst_sym_valid", {7'd0, bus.sym_valid}, 8'd0);
    chk("rst_sym_dash", {7'd0, bus.sym_dash}, 8'd0);
    chk("rst_busy", {7'd0, bus.busy}, 8'd0);
    chk("rst_progress", {4'd0, bus.progress}, 8'd0);
    chk("rst_sos", {7'd0, bus.sos}, 8'd0);
    chk("rst_err", {7'd0, bus.err}, 8'd0);
    rst = 1'b0;
    repeat (3) bit_(1'b0);

    // Full match
    s0 = n_sym; q0 = n_sos; e0 = n_err;
    run_from(0);
    repeat (4) bit_(1'b0);
    chk("full_nsym", 8'(n_sym - s0), 8'd9);
    chk("full_nsos", 8'(n_sos - q0), 8'd1);
    chk("full_nerr", 8'(n_err - e0), 8'd0);

    // Bad run of length 2
    s0 = n_sym; e0 = n_err;
    sym(1'b0);
    sym(1'b0);
    bit_(1'b1);
    bit_(1'b1);
    bit_(1'b0);
    chk("bad_no_valid", {7'd0, bus.sym_valid}, 8'd0);
    chk("bad_prog_before", {4'd0, bus.progress}, 8'd2);
    bit_(1'b0);
    chk("bad_prog_after", {4'd0, bus.progress}, 8'd0);
    chk("bad_busy", {7'd0, bus.busy}, 8'd0);
    repeat (12) bit_(1'b0);
    chk("bad_nsym", 8'(n_sym - s0), 8'd2);
    chk("bad_nerr", 8'(n_err - e0), 8'd0);

    // Timeout: gap reaches 8 after seven extra zeros, err follows one cycle later
    e0 = n_err;
    sym(1'b0);
    sym(1'b0);
    repeat (7) bit_(1'b0);
    chk("to_prog_wait", {4'd0, bus.progress}, 8'd2);
    chk("to_err_early", {7'd0, bus.err}, 8'd0);
    bit_(1'b0);
    chk("to_err", {7'd0, bus.err}, 8'd1);
    chk("to_prog", {4'd0, bus.progress}, 8'd0);
    bit_(1'b0);
    chk("to_err_clear", {7'd0, bus.err}, 8'd0);
    repeat (12) bit_(1'b0);
    chk("to_nerr", 8'(n_err - e0), 8'd1);

    // Mismatch restart
    q0 = n_sos;
    sym(1'b0);
    sym(1'b0);
    sym(1'b0);
    sym(1'b1);
    sym(1'b0);
    chk("mm_prog4", {4'd0, bus.progress}, 8'd4);
    run_from(1);
    chk("mm_nsos", 8'(n_sos - q0), 8'd1);
    repeat (3) bit_(1'b0);

    // Reset mid-match
    e0 = n_err; q0 = n_sos;
    sym(1'b0);
    sym(1'b0);
    sym(1'b0);
    sym(1'b1);
    rst = 1'b1;
    bit_(1'b0);
    rst = 1'b0;
    chk("mr_sym_valid", {7'd0, bus.sym_valid}, 8'd0);
    chk("mr_progress", {4'd0, bus.progress}, 8'd0);
    chk("mr_busy", {7'd0, bus.busy}, 8'd0);
    chk("mr_err", {7'd0, bus.err}, 8'd0);
    chk("mr_sos", {7'd0, bus.sos}, 8'd0);
    repeat (10) bit_(1'b0);
    chk("mr_nerr", 8'(n_err - e0), 8'd0);
    run_from(0);
    chk("mr_nsos", 8'(n_sos - q0), 8'd1);

    // Saturated run
    s0 = n_sym; q0 = n_sos;
    repeat (16) bit_(1'b1);
    bit_(1'b0);
    chk("sat_no_valid", {7'd0, bus.sym_valid}, 8'd0);
    bit_(1'b0);
    chk("sat_progress", {4'd0, bus.progress}, 8'd0);
    chk("sat_nsym", 8'(n_sym - s0), 8'd0);
    run_from(0);
    chk("sat_nsos", 8'(n_sos - q0), 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
